// File: rtl/dino_game_ctrl.sv
// Purpose : game sequencer for the dot-matrix runner: scroll/spawn timing, jump phase, crouch, score, run/over status.
// Latency : scroll/spawn/score/jump update one clock after the sampled tick; collision moves to OVER the next clock.
// Backpr. : none; the map datapath must accept every scroll/spawn pulse as issued.
module dino_game_ctrl #(
  parameter int TICK_DIV_INIT = 8,   // ticks per scroll step at game start
  parameter int TICK_DIV_MIN  = 3,   // fastest scroll period, 1..TICK_DIV_INIT
  parameter int SPEEDUP_PTS   = 16,  // points per speed-up step, power of two >= 2
  parameter int SPAWN_GAP     = 4,   // minimum scroll steps between spawns
  parameter int JUMP_LEN      = 9,   // jump duration in ticks, <= 15
  parameter int DEAD_HOLD     = 16,  // ticks spent in OVER
  parameter int SCORE_W       = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_start,
  input  logic               i_up,
  input  logic               i_down,
  input  logic               i_hit,
  input  logic [1:0]         i_rnd,
  output logic               o_scroll,
  output logic               o_spawn,
  output logic [3:0]         o_jump_cnt,
  output logic               o_jumping,
  output logic               o_crouch,
  output logic               o_running,
  output logic               o_game_over,
  output logic [SCORE_W-1:0] o_score
);

  localparam int DIV_W  = $clog2(TICK_DIV_INIT + 1);
  localparam int GAP_W  = $clog2(2 * SPAWN_GAP) + 1;
  localparam int HOLD_W = $clog2(DEAD_HOLD + 1);
  localparam int SPD_W  = $clog2(SPEEDUP_PTS);

  localparam logic [DIV_W-1:0]   DIV_INIT  = DIV_W'(TICK_DIV_INIT);
  localparam logic [DIV_W-1:0]   DIV_MIN   = DIV_W'(TICK_DIV_MIN);
  localparam logic [GAP_W-1:0]   GAP_LO    = GAP_W'(SPAWN_GAP - 1);
  localparam logic [GAP_W-1:0]   GAP_HI    = GAP_W'(2 * SPAWN_GAP - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(DEAD_HOLD - 1);
  localparam logic [3:0]         JUMP_LAST = 4'(JUMP_LEN);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_running;
  logic                r_game_over;

  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    r_tick_cnt;
  logic [GAP_W-1:0]    r_gap;
  logic [SCORE_W-1:0]  r_score;
  logic                r_scroll;
  logic                r_spawn;

  logic [3:0]          r_jump_cnt;
  logic                r_jumping;
  logic                r_crouch;

  logic                w_start;
  logic                w_run_ok;
  logic                w_hold_done;
  logic                w_period_end;
  logic                w_spawn;
  logic                w_can_inc;
  logic [SCORE_W-1:0]  w_score_nxt;
  logic                w_speedup;
  logic [DIV_W-1:0]    w_div_dec;

  // A collision always wins over anything the run would do in the same clock.
  assign w_start      = (r_state == S_IDLE) && i_start;
  assign w_run_ok     = (r_state == S_RUN) && !i_hit;
  assign w_hold_done  = (r_state == S_OVER) && i_tick && (r_hold == HOLD_LAST);
  assign w_period_end = i_tick && (r_tick_cnt == r_div - DIV_W'(1));
  assign w_spawn      = ((r_gap >= GAP_LO) && (i_rnd != 2'b00)) || (r_gap == GAP_HI);
  assign w_can_inc    = (r_score != SCORE_MAX);
  assign w_score_nxt  = r_score + SCORE_W'(1);
  assign w_speedup    = w_can_inc && (w_score_nxt[SPD_W-1:0] == '0);
  assign w_div_dec    = (r_div > DIV_MIN) ? (r_div - DIV_W'(1)) : DIV_MIN;

  // Game state machine with registered run/over status and the OVER hold timer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_running   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (i_hit) begin
            r_state     <= S_OVER;
            r_running   <= 1'b0;
            r_game_over <= 1'b1;
            r_hold      <= '0;
          end
        end
        S_OVER: begin
          if (i_tick) begin
            if (r_hold == HOLD_LAST) begin
              r_state     <= S_IDLE;
              r_game_over <= 1'b0;
              r_hold      <= '0;
            end else begin
              r_hold <= r_hold + HOLD_W'(1);
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_running   <= 1'b0;
          r_game_over <= 1'b0;
          r_hold      <= '0;
        end
      endcase
    end
  end

  // Scroll period counter, speed-up, spawn spacing and score; outputs pulse one clock after the closing tick.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div      <= DIV_INIT;
      r_tick_cnt <= '0;
      r_gap      <= '0;
      r_score    <= '0;
      r_scroll   <= 1'b0;
      r_spawn    <= 1'b0;
    end else begin
      r_scroll <= 1'b0;
      r_spawn  <= 1'b0;
      if (w_start) begin
        r_div      <= DIV_INIT;
        r_tick_cnt <= '0;
        r_gap      <= '0;
        r_score    <= '0;
      end else if (w_run_ok && i_tick) begin
        if (w_period_end) begin
          r_tick_cnt <= '0;
          r_scroll   <= 1'b1;
          r_spawn    <= w_spawn;
          r_gap      <= w_spawn ? '0 : (r_gap + GAP_W'(1));
          // Score saturates; the divider only steps on a real increment.
          if (w_can_inc) begin
            r_score <= w_score_nxt;
            if (w_speedup) begin
              r_div <= w_div_dec;
            end
          end
        end else begin
          r_tick_cnt <= r_tick_cnt + DIV_W'(1);
        end
      end
    end
  end

  // Jump phase advances on ticks while running; crouch follows the button only while running.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_jump_cnt <= '0;
      r_jumping  <= 1'b0;
      r_crouch   <= 1'b0;
    end else begin
      r_crouch <= w_run_ok ? i_down : 1'b0;
      if (w_start || w_hold_done) begin
        r_jump_cnt <= '0;
        r_jumping  <= 1'b0;
      end else if (w_run_ok && i_tick) begin
        if (!r_jumping) begin
          if (i_up) begin
            r_jump_cnt <= 4'd1;
            r_jumping  <= 1'b1;
          end
        end else if (r_jump_cnt == JUMP_LAST) begin
          r_jump_cnt <= '0;
          r_jumping  <= 1'b0;
        end else begin
          r_jump_cnt <= r_jump_cnt + 4'd1;
        end
      end
    end
  end

  assign o_scroll    = r_scroll;
  assign o_spawn     = r_spawn;
  assign o_jump_cnt  = r_jump_cnt;
  assign o_jumping   = r_jumping;
  assign o_crouch    = r_crouch;
  assign o_running   = r_running;
  assign o_game_over = r_game_over;
  assign o_score     = r_score;

endmodule
